bus_router_1to4: RTL and testbench

//  Address-decoding router: one bus master to four slaves, same valid/ready/addr/rdata/wdata/wstrb protocol
//  as the bus arbiters. Sits between the arbitrated master bus and the memory and peripheral slaves.

---
 rtl/bus_router_1to4.sv | 143 ++++++++++++++
 tb/tb_bus_router_1to4.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_router_1to4.sv
// One-master to four-slave address router with registered slave select,
// decode/timeout error responses and sticky error bookkeeping.
//
// state | meaning
// IDLE  | decode cycle; no slave driven
// FWD   | request forwarded to slave sel, timer counting hold-off cycles
// DERR  | error response for an unmapped address
// TOUT  | error response for a slave that held off ready too long
module bus_router_1to4 #(
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S0_MASK  = 32'hF000_0000,
    parameter logic [31:0] S1_BASE  = 32'h1000_0000,
    parameter logic [31:0] S1_MASK  = 32'hF000_0000,
    parameter logic [31:0] S2_BASE  = 32'h2000_0000,
    parameter logic [31:0] S2_MASK  = 32'hF000_0000,
    parameter logic [31:0] S3_BASE  = 32'h8000_0000,
    parameter logic [31:0] S3_MASK  = 32'h8000_0000,
    parameter logic [15:0] TIMEOUT  = 16'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         m_valid,
    output logic         m_ready,
    input  logic [31:0]  m_addr,
    output logic [31:0]  m_rdata,
    input  logic [31:0]  m_wdata,
    input  logic [3:0]   m_wstrb,
    output logic [3:0]   s_valid,
    input  logic [3:0]   s_ready,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
    input  logic [127:0] s_rdata,
    output logic         err_decode,
    output logic         err_timeout,
    output logic [7:0]   err_count,
    output logic [31:0]  last_err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DERR = 2'd2,
        TOUT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sel;
    logic [15:0] timer;
    logic        hit;
    logic [1:0]  hit_idx;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        tout_hit;
    logic        err_enter;

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    // Checked highest index first so the lowest matching window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        if ((m_addr & S3_MASK) == S3_BASE) begin hit = 1'b1; hit_idx = 2'd3; end
        if ((m_addr & S2_MASK) == S2_BASE) begin hit = 1'b1; hit_idx = 2'd2; end
        if ((m_addr & S1_MASK) == S1_BASE) begin hit = 1'b1; hit_idx = 2'd1; end
        if ((m_addr & S0_MASK) == S0_BASE) begin hit = 1'b1; hit_idx = 2'd0; end
    end

    assign sel_ready = s_ready[sel];
    assign sel_rdata = s_rdata[{sel, 5'd0} +: 32];
    assign tout_hit  = (TIMEOUT != 16'd0) && (timer == TIMEOUT - 16'd1);
    assign err_enter = (state_nxt == DERR) || (state_nxt == TOUT);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (m_valid) state_nxt = hit ? FWD : DERR;
            FWD: begin
                if (!m_valid || sel_ready) state_nxt = IDLE;
                else if (tout_hit)         state_nxt = TOUT;
            end
            DERR:    state_nxt = IDLE;
            TOUT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_valid     = 4'd0;
        m_ready     = 1'b0;
        m_rdata     = 32'd0;
        err_decode  = 1'b0;
        err_timeout = 1'b0;
        case (state)
            FWD: begin
                s_valid[sel] = m_valid;
                m_ready      = sel_ready;
                m_rdata      = sel_rdata;
            end
            DERR: begin
                m_ready    = 1'b1;
                m_rdata    = ERR_DATA;
                err_decode = 1'b1;
            end
            TOUT: begin
                m_ready     = 1'b1;
                m_rdata     = ERR_DATA;
                err_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel           <= 2'd0;
            timer         <= 16'd0;
            err_count     <= 8'd0;
            last_err_addr <= 32'd0;
        end else begin
            if (state == IDLE && m_valid && hit) begin
                sel   <= hit_idx;
                timer <= 16'd0;
            end else if (state == FWD && state_nxt == FWD) begin
                timer <= timer + 16'd1;
            end
            if (err_enter) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                last_err_addr <= m_addr;
            end
        end
    end

endmodule

// File: tb/tb_bus_router_1to4.sv
// Directed bench for bus_router_1to4: routing, wait states, decode and
// timeout errors, mid-transaction reset, saturation and abort.
module tb_bus_router_1to4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_addr;
    logic [31:0]  m_rdata;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [127:0] s_rdata;
    logic         err_decode;
    logic         err_timeout;
    logic [7:0]   err_count;
    logic [31:0]  last_err_addr;

    int n_checks = 0;
    int n_errors = 0;

    bus_router_1to4 #(.TIMEOUT(16'd8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_addr        (m_addr),
        .m_rdata       (m_rdata),
        .m_wdata       (m_wdata),
        .m_wstrb       (m_wstrb),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .s_rdata       (s_rdata),
        .err_decode    (err_decode),
        .err_timeout   (err_timeout),
        .err_count     (err_count),
        .last_err_addr (last_err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends in an IDLE cycle.
    task automatic read_s1(input string tag);
        m_valid = 1'b1; m_addr = 32'h1000_0010; m_wstrb = 4'h0; s_ready = 4'h0;
        #1 chk({tag, "_idle_sv"}, 32'(s_valid), 32'h0);
        tick();
        s_ready = 4'b0010;
        #1;
        chk({tag, "_sv"},    32'(s_valid), 32'h2);
        chk({tag, "_rdy"},   32'(m_ready), 32'h1);
        chk({tag, "_rdata"}, m_rdata,      32'h1234_5678);
        tick();
        m_valid = 1'b0; s_ready = 4'h0;
        #1;
        chk({tag, "_sv2"},  32'(s_valid), 32'h0);
        chk({tag, "_rdy2"}, 32'(m_ready), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; m_valid = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
        s_ready = 4'h0;
        s_rdata = {32'hCCCC_3333, 32'hBBBB_2222, 32'h1234_5678, 32'hAAAA_0000};
        tick(); tick();
        chk("rst_sv",    32'(s_valid),    32'h0);
        chk("rst_rdy",   32'(m_ready),    32'h0);
        chk("rst_rdata", m_rdata,         32'h0);
        chk("rst_edec",  32'(err_decode), 32'h0);
        chk("rst_ecnt",  32'(err_count),  32'h0);
        chk("rst_eaddr", last_err_addr,   32'h0);
        resetn = 1'b1;
        tick();

        read_s1("t1");

        // write to slave2 with three wait states; slave1 ready must be ignored
        m_valid = 1'b1; m_addr = 32'h2000_0004; m_wstrb = 4'hF; m_wdata = 32'hA5A5_0F0F;
        tick();
        for (int i = 1; i <= 3; i++) begin
            s_ready = 4'b0010;
            #1;
            chk("t2_sv",    32'(s_valid), 32'h4);
            chk("t2_rdy",   32'(m_ready), 32'h0);
            chk("t2_wstrb", 32'(s_wstrb), 32'hF);
            chk("t2_wdata", s_wdata,      32'hA5A5_0F0F);
            tick();
        end
        s_ready = 4'b0100;
        #1;
        chk("t2_sv4",  32'(s_valid), 32'h4);
        chk("t2_rdy4", 32'(m_ready), 32'h1);
        chk("t2_addr", s_addr,       32'h2000_0004);
        tick();
        m_valid = 1'b0; s_ready = 4'h0; m_wstrb = 4'h0;
        #1;
        chk("t2_sv5",  32'(s_valid), 32'h0);
        chk("t2_rdy5", 32'(m_ready), 32'h0);

        // unmapped read
        m_valid = 1'b1; m_addr = 32'h4000_0000;
        tick();
        chk("t3_rdy",   32'(m_ready),    32'h1);
        chk("t3_rdata", m_rdata,         32'hDEAD_BEEF);
        chk("t3_edec",  32'(err_decode), 32'h1);
        chk("t3_ecnt",  32'(err_count),  32'h1);
        chk("t3_eaddr", last_err_addr,   32'h4000_0000);
        chk("t3_sv",    32'(s_valid),    32'h0);
        tick();
        m_valid = 1'b0;
        #1;
        chk("t3_edec2", 32'(err_decode), 32'h0);
        chk("t3_rdy2",  32'(m_ready),    32'h0);

        // slave0 never answers: eight forwarded cycles, then timeout response
        m_valid = 1'b1; m_addr = 32'h0000_0100;
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk("t4_sv",  32'(s_valid), 32'h1);
            chk("t4_rdy", 32'(m_ready), 32'h0);
            tick();
        end
        chk("t4_rdy9",  32'(m_ready),     32'h1);
        chk("t4_rdata", m_rdata,          32'hDEAD_BEEF);
        chk("t4_etout", 32'(err_timeout), 32'h1);
        chk("t4_sv9",   32'(s_valid),     32'h0);
        chk("t4_ecnt",  32'(err_count),   32'h2);
        chk("t4_eaddr", last_err_addr,    32'h0000_0100);
        tick();
        m_valid = 1'b0;
        #1 chk("t4_etout2", 32'(err_timeout), 32'h0);

        // ready on the last allowed cycle completes normally
        m_valid = 1'b1; m_addr = 32'h0000_0200;
        tick();
        for (int i = 1; i <= 7; i++) begin
            chk("tb_sv", 32'(s_valid), 32'h1);
            tick();
        end
        s_ready = 4'b0001;
        #1;
        chk("tb_rdy",   32'(m_ready),     32'h1);
        chk("tb_rdata", m_rdata,          32'hAAAA_0000);
        chk("tb_etout", 32'(err_timeout), 32'h0);
        tick();
        m_valid = 1'b0; s_ready = 4'h0;
        #1;
        chk("tb_rdy2",   32'(m_ready),     32'h0);
        chk("tb_etout2", 32'(err_timeout), 32'h0);
        chk("tb_ecnt",   32'(err_count),   32'h2);

        // reset during a forwarded write
        m_valid = 1'b1; m_addr = 32'h2000_0004; m_wstrb = 4'hF; m_wdata = 32'hA5A5_0F0F;
        tick();
        resetn = 1'b0;
        #1 chk("t5_sv_fwd", 32'(s_valid), 32'h4);
        tick();
        chk("t5_sv",    32'(s_valid),   32'h0);
        chk("t5_rdy",   32'(m_ready),   32'h0);
        chk("t5_ecnt",  32'(err_count), 32'h0);
        chk("t5_eaddr", last_err_addr,  32'h0);
        resetn = 1'b1; m_valid = 1'b0; m_wstrb = 4'h0;
        tick();
        read_s1("t5r");

        // saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            m_valid = 1'b1; m_addr = 32'h4000_0000 | 32'(i);
            tick();
            tick();
        end
        m_valid = 1'b0;
        #1;
        chk("t6_ecnt",  32'(err_count), 32'hFF);
        chk("t6_eaddr", last_err_addr,  32'h4000_0103);
        tick();

        // abort while forwarding
        m_valid = 1'b1; m_addr = 32'h1000_0000;
        tick();
        chk("t6_ab_sv", 32'(s_valid), 32'h2);
        m_valid = 1'b0;
        #1 chk("t6_ab_sv0", 32'(s_valid), 32'h0);
        tick();
        chk("t6_ab_rdy",  32'(m_ready),     32'h0);
        chk("t6_ab_etout", 32'(err_timeout), 32'h0);
        chk("t6_ab_edec", 32'(err_decode),  32'h0);
        chk("t6_ab_ecnt", 32'(err_count),   32'hFF);
        tick();

        // top address lands in slave3
        m_valid = 1'b1; m_addr = 32'hFFFF_FFF0;
        tick();
        s_ready = 4'b1000;
        #1;
        chk("t6_s3_sv",    32'(s_valid), 32'h8);
        chk("t6_s3_rdy",   32'(m_ready), 32'h1);
        chk("t6_s3_rdata", m_rdata,      32'hCCCC_3333);
        tick();
        m_valid = 1'b0; s_ready = 4'h0;
        #1 chk("t6_s3_sv2", 32'(s_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
